// File: rtl/pipe_hazard_ctrl.sv
// Purpose : pipeline sequencing controller; write enables, flushes and bubbles for IF/ID, ID/EX, EX/MEM, MEM/WB.
// Latency : hazard response is combinational (0 cycles); state, stall counter and timeout flag update on clk.
// Backpress: a pending data-memory access (dmem_req & !dmem_ready) freezes every pipeline register.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_rs1/id_rs2, id_uses_*   source registers read by the instruction in ID
//   ex_rd, ex_mem_read         destination / load flag of the instruction in EX
//   ex_redirect                taken branch or jump resolved in EX
//   ex_muldiv_start, muldiv_done  multi-cycle mul/div handshake
//   dmem_req, dmem_ready       data-memory handshake in MEM
//   pc_we .. mem_wb_we         per-register write enables, flush and bubble controls
//   stall_cycles               saturating count of cycles with pc_we low
//   mem_timeout                sticky flag: memory wait reached MEM_TIMEOUT cycles
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             ex_mem_bubble,
    output logic             mem_wb_we,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_d;

    logic freeze;
    logic load_use;
    logic md_wait;
    logic md_done;

    always_comb begin
        freeze   = dmem_req & ~dmem_ready;
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
        // The start cycle already holds the front end; once busy, only done releases it.
        md_wait  = (state_q == MD_BUSY) ? ~muldiv_done : ex_muldiv_start;
        md_done  = (state_q == MD_BUSY) && muldiv_done;
    end

    // Hazard response, highest priority first.
    always_comb begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_we     = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_we     = 1'b0;
        if (!rst_n || freeze) begin
            // everything held
        end else if (md_wait) begin
            // Front end holds; EX/MEM takes NOPs while the older instructions drain.
            ex_mem_we     = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_we     = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            // The mul/div completion cycle is a plain advance so the result moves on.
            if (!md_done) begin
                if (ex_redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (freeze) begin
            // MD_BUSY is kept across a memory wait: the mul/div unit keeps running.
            if (state_q == RUN) begin
                state_d = MEM_WAIT;
            end
        end else if (state_q == MD_BUSY) begin
            if (muldiv_done) begin
                state_d = RUN;
            end
        end else begin
            // RUN, or MEM_WAIT on its release cycle, which behaves as RUN.
            state_d = ex_muldiv_start ? MD_BUSY : RUN;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == TMO_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (freeze && (wait_cnt_d == TMO_LIMIT));

        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
// Latency : expected outputs are queued as each cycle is driven and compared #1 later.
// Backpress: not applicable; the bench drives every input each cycle.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic       ex_muldiv_start = 1'b0, muldiv_done = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
    logic       ex_mem_we, ex_mem_bubble, mem_wb_we;
    logic [3:0] stall_cycles;
    logic       mem_timeout;

    // Output vector order: pc_we, if_id_we, if_id_flush, id_ex_we,
    //                      id_ex_bubble, ex_mem_we, ex_mem_bubble, mem_wb_we
    localparam logic [7:0] O_ZERO  = 8'b0000_0000;
    localparam logic [7:0] O_NORM  = 8'b1101_0101;
    localparam logic [7:0] O_MD    = 8'b0000_0111;
    localparam logic [7:0] O_REDIR = 8'b1111_1101;
    localparam logic [7:0] O_LU    = 8'b0001_1101;

    typedef struct packed {
        logic [7:0] o;
        logic [3:0] st;
        logic       tmo;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_stall = 4'd0;
    logic       exp_tmo = 1'b0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_muldiv_start(ex_muldiv_start), .muldiv_done(muldiv_done),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
        .ex_mem_we(ex_mem_we), .ex_mem_bubble(ex_mem_bubble), .mem_wb_we(mem_wb_we),
        .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag, input logic [7:0] exp_o);
        exp_t e, g;
        logic [7:0] got_o;
        e.o = exp_o; e.st = exp_stall; e.tmo = exp_tmo;
        sb_q.push_back(e);
        #1;
        got_o = {pc_we, if_id_we, if_id_flush, id_ex_we,
                 id_ex_bubble, ex_mem_we, ex_mem_bubble, mem_wb_we};
        g = sb_q.pop_front();
        chk({tag, "_out"},   32'(got_o),        32'(g.o));
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(g.st));
        chk({tag, "_tmo"},   32'(mem_timeout),  32'(g.tmo));
        if (!rst_n) begin
            exp_stall = 4'd0;
            exp_tmo   = 1'b0;
        end else if (!exp_o[7] && exp_stall != 4'hF) begin
            exp_stall = exp_stall + 4'd1;
        end
        @(negedge clk);
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset with an active redirect: all controls held low
        ex_redirect = 1'b1;
        step("rst", O_ZERO);
        idle(); step("norm", O_NORM);

        // load-use on rs1, one bubble, then hazard gone
        set_lu(5'd5); step("lu_rs1", O_LU);
        idle(); step("lu_after", O_NORM);
        // load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        step("lu_rs2", O_LU);
        // x0 destination never stalls
        idle(); set_lu(5'd0); step("lu_x0", O_NORM);
        // match but rs1 not used
        idle(); set_lu(5'd5); id_uses_rs1 = 1'b0; step("lu_unused", O_NORM);
        // match but not a load
        idle(); set_lu(5'd9); ex_mem_read = 1'b0; step("lu_noload", O_NORM);
        // redirect wins over load-use, then redirect alone
        idle(); set_lu(5'd5); ex_redirect = 1'b1; step("redir_lu", O_REDIR);
        idle(); ex_redirect = 1'b1; step("redir", O_REDIR);

        // mul/div: start + 3 busy cycles, done cycle normal, then RUN
        idle(); ex_muldiv_start = 1'b1; step("md_start", O_MD);
        for (int i = 0; i < 3; i++) begin
            idle(); step("md_busy", O_MD);
        end
        idle(); muldiv_done = 1'b1; step("md_done", O_NORM);
        idle(); set_lu(5'd4); step("md_run", O_LU);
        idle(); muldiv_done = 1'b1; step("md_done_run", O_NORM);

        // memory wait inside MD_BUSY; done during freeze must not leave MD_BUSY
        idle(); ex_muldiv_start = 1'b1; step("mdw_start", O_MD);
        for (int i = 0; i < 3; i++) begin
            idle(); dmem_req = 1'b1; muldiv_done = (i == 2); step("mdw_frz", O_ZERO);
        end
        idle(); step("mdw_busy", O_MD);
        idle(); muldiv_done = 1'b1; step("mdw_done", O_NORM);
        idle(); set_lu(5'd6); step("mdw_run", O_LU);

        // stall counter saturation
        idle(); rst_n = 1'b0; step("rst2", O_ZERO);
        for (int i = 0; i < 20; i++) begin
            idle(); set_lu(5'd8); step("sat", O_LU);
        end
        idle(); step("sat_end", O_NORM);

        // reset mid MD_BUSY aborts it
        idle(); rst_n = 1'b0; step("rst3", O_ZERO);
        idle(); ex_muldiv_start = 1'b1; step("mdr_start", O_MD);
        idle(); step("mdr_busy", O_MD);
        idle(); rst_n = 1'b0; ex_redirect = 1'b1; step("mdr_rst", O_ZERO);
        idle(); step("mdr_norm", O_NORM);
        idle(); set_lu(5'd2); step("mdr_run", O_LU);

        // timeout: 7-cycle wait clears the counter, 8-cycle wait sets the flag
        idle(); rst_n = 1'b0; step("rst4", O_ZERO);
        for (int i = 0; i < 7; i++) begin
            idle(); dmem_req = 1'b1; step("tmo_short", O_ZERO);
        end
        idle(); step("tmo_gap", O_NORM);
        for (int i = 0; i < 8; i++) begin
            idle(); dmem_req = 1'b1; step("tmo_long", O_ZERO);
        end
        exp_tmo = 1'b1;
        // release cycle is evaluated normally, here with a load-use
        idle(); dmem_req = 1'b1; dmem_ready = 1'b1; set_lu(5'd3); step("tmo_rel", O_LU);
        idle(); step("tmo_sticky", O_NORM);
        idle(); rst_n = 1'b0; step("rst5", O_ZERO);
        idle(); step("tmo_clr", O_NORM);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It watches the ID, EX and MEM stages and produces per-register write enables, flushes and bubble requests for IF/ID, ID/EX, EX/MEM and MEM/WB. Its `id_ex_bubble` output drives the `stall` input of the decode control mux. It also counts frozen cycles and flags a data-memory handshake timeout.

## Interface

**Parameters**
- `MEM_TIMEOUT`, default 255: maximum number of consecutive `dmem_ready`-low cycles before `mem_timeout` is set.
- `CNT_W`, default 16: width of the stall counter.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction reads rs1 / rs2.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_redirect` in 1: branch taken or jump resolved in EX.
- `ex_muldiv_start` in 1: a multi-cycle mul/div entered EX this cycle.
- `muldiv_done` in 1: the mul/div result is valid this cycle.
- `dmem_req` in 1: MEM stage has a load or store outstanding.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_we` out 1: PC register write enable.
- `if_id_we` out 1: IF/ID register write enable.
- `if_id_flush` out 1: IF/ID register loads a NOP.
- `id_ex_we` out 1: ID/EX register write enable.
- `id_ex_bubble` out 1: zero the decoded control word; connects to the decode mux `stall` input.
- `ex_mem_we` out 1: EX/MEM register write enable.
- `ex_mem_bubble` out 1: EX/MEM register loads a NOP.
- `mem_wb_we` out 1: MEM/WB register write enable.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `pc_we`=0.
- `mem_timeout` out 1: sticky error flag.

## Operation

**State register**
- States: RUN, MEM_WAIT, MD_BUSY. Reset state is RUN.
- Outputs are combinational from the state and the current inputs.

**Reset**
- While `rst_n`=0, every enable, flush and bubble output is 0.
- On the edge sampled with `rst_n`=0: state goes to RUN, the MEM_WAIT counter clears, `stall_cycles` clears to 0 and `mem_timeout` clears to 0.
- A reset asserted mid-MEM_WAIT or mid-MD_BUSY aborts the operation; the next cycle is RUN.

**Priority, highest first**
1. **freeze**, when `dmem_req`=1 and `dmem_ready`=0.
   - All `*_we` are 0; all flush and bubble outputs are 0.
   - Applies in any state.
   - From RUN, the state goes to MEM_WAIT.
   - The MD_BUSY state is held, and the mul/div unit keeps running.
2. **MD_BUSY with `muldiv_done`=0**.
   - `pc_we`, `if_id_we` and `id_ex_we` are 0.
   - `ex_mem_we`=1 and `ex_mem_bubble`=1.
   - `mem_wb_we`=1.
3. **redirect**, when `ex_redirect`=1.
   - All `*_we` are 1.
   - `if_id_flush`=1 and `id_ex_bubble`=1.
   - Redirect overrides load-use.
4. **load-use**, when all of the following hold:
   - `ex_mem_read`=1 and `ex_rd`≠0;
   - `id_uses_rs1` with `id_rs1`==`ex_rd`, or `id_uses_rs2` with `id_rs2`==`ex_rd`.
   - Response: `pc_we`=0, `if_id_we`=0, `id_ex_we`=1, `id_ex_bubble`=1, and the remaining enables are 1.
5. **normal**: all `*_we`=1; all flush and bubble outputs are 0.

**Transitions**
- RUN → MD_BUSY when `ex_muldiv_start`=1 and freeze=0.
  - The start cycle itself applies the MD_BUSY response (priority 2).
- MD_BUSY → RUN on a cycle with `muldiv_done`=1 and freeze=0.
  - That cycle is normal: all `*_we`=1 and no bubbles, so the result advances.
- MEM_WAIT → RUN on the first cycle with `dmem_ready`=1.
  - That cycle is evaluated with priorities 2–5.
- `muldiv_done` while in RUN is ignored.

**Counters**
- The MEM_WAIT counter increments on every freeze cycle and clears when freeze is 0.
- `mem_timeout` sets when the counter reaches `MEM_TIMEOUT`. It stays set until reset.
- `stall_cycles` increments on every non-reset cycle with `pc_we`=0. It saturates at all-ones.

## Timing
- Hazard response latency is 0 cycles: outputs are combinational in the same cycle as the inputs.
- State, counters and `mem_timeout` update on the rising edge.
- A load-use hazard costs exactly 1 bubble cycle. The next cycle the load is in MEM, so the hazard clears.
- A redirect costs 2 squashed instructions (IF/ID and ID/EX).
- A mul/div taking N cycles from start to `muldiv_done` costs N bubbles into EX/MEM. The start cycle is counted; the done cycle is not.
- `mem_timeout` rises on the edge after the `MEM_TIMEOUT`-th consecutive freeze cycle.

## Test plan
- **Load-use on rs1 and rs2.** Set `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 → `pc_we`=0, `if_id_we`=0, `id_ex_bubble`=1 for 1 cycle, `stall_cycles`=1. Repeat with `ex_rd`=0 → no stall.
- **Redirect beats load-use.** Assert `ex_redirect`=1 together with a load-use match → `if_id_flush`=1, `id_ex_bubble`=1, `pc_we`=1.
- **Mul/div stall.** Assert `ex_muldiv_start`, then `muldiv_done` 4 cycles later → 4 cycles of `ex_mem_bubble`=1 with `pc_we`=0, then 1 normal cycle, then state RUN.
- **Memory wait inside MD_BUSY.** Hold `dmem_req`=1, `dmem_ready`=0 for 3 cycles during MD_BUSY → all enables 0; the state stays MD_BUSY. After release, `muldiv_done` returns the block to RUN.
- **Timeout.** Use `MEM_TIMEOUT`=8 and hold freeze for 8 cycles → `mem_timeout`=1 on the next edge. It stays 1 after `dmem_ready` until `rst_n`=0.
- **Reset and saturation.** Pulse `rst_n`=0 mid-MD_BUSY → all outputs 0 during reset, then RUN with `stall_cycles`=0. With `CNT_W`=4, hold a stall for 20 cycles → `stall_cycles`=15.
